tt_um_jimktrains_vslc_eeprom_writer: RTL

SPI EEPROM page writer for the VSLC program store. It is the write-side counterpart of the core's EEPROM reader, targeting the same 25xx-style serial EEPROM (SPI mode 0, 16-bit address). A byte stream with a valid/ready handshake is written starting at a given address. The block issues WREN/WRITE, splits the stream on page boundaries, and polls RDSR until the write cycle finishes. It is used by the in-system programming path to load ladder programs without removing the EEPROM.

---
 rtl/tt_um_jimktrains_vslc_eeprom_writer.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tt_um_jimktrains_vslc_eeprom_writer.sv
// -----------------------------------------------------------------------------
// tt_um_jimktrains_vslc_eeprom_writer
//
// Writes a valid/ready byte stream into a 25xx-style SPI EEPROM (SPI mode 0,
// 16-bit address) starting at start_addr. Every page is written as
// WREN, then WRITE + address + data bytes, then RDSR polling until WIP clears.
// A page boundary closes the current WRITE and opens a new one after polling.
//
// Parameters
//   CLK_DIV     SCK half-period in clk cycles (>= 1)
//   PAGE_BYTES  EEPROM page size (power of two, 8..256)
//   POLL_LIMIT  status bytes read per write cycle before giving up
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, start_addr  1-cycle job request and first byte address
//   data_in/valid/last byte stream input, data_ready accepts a byte
//   busy, done, error  job status (error = poll timeout, kept until next start)
//   cur_addr           address of the next byte to be written
//   sck, cs_n, copi    SPI master outputs, copi_oe enables the shared SD pin
//   cipo               SPI status input
//   hold_n             tied high
// -----------------------------------------------------------------------------
module tt_um_jimktrains_vslc_eeprom_writer #(
   parameter int unsigned CLK_DIV    = 3,
   parameter int unsigned PAGE_BYTES = 32,
   parameter int unsigned POLL_LIMIT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] start_addr,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   input  logic        data_last,
   output logic        data_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] cur_addr,
   output logic        sck,
   output logic        cs_n,
   output logic        copi,
   output logic        copi_oe,
   input  logic        cipo,
   output logic        hold_n
);

   localparam int unsigned DIV_W = $clog2(2 * CLK_DIV + 1);
   localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

   localparam logic [DIV_W-1:0] HALF_END  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] GAP_END   = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [CNT_W-1:0] POLL_MAX  = CNT_W'(POLL_LIMIT);
   localparam logic [15:0]      PAGE_MASK = 16'(PAGE_BYTES - 1);

   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_RDSR  = 8'h05;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WREN,
      S_GAP,
      S_CMD,
      S_DATA,
      S_END,
      S_POLL_CMD,
      S_POLL_RD,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   state_t           tgt_q, tgt_d;     // where END/GAP lead to
   logic [DIV_W-1:0] div_q, div_d;     // cycles spent in the current half-period
   logic             sck_q, sck_d;
   logic             cs_n_q, cs_n_d;
   logic [31:0]      sh_q, sh_d;       // transmit shifter, MSB is on copi
   logic [5:0]       bits_q, bits_d;   // bits left in the current burst
   logic [7:0]       rx_q, rx_d;
   logic [15:0]      addr_q, addr_d;
   logic [CNT_W-1:0] poll_q, poll_d;
   logic             last_q, last_d;
   logic             brk_q, brk_d;     // write stopped at a page boundary
   logic             tmo_q, tmo_d;     // poll timed out, reported with done
   logic             err_q, err_d;
   logic             xfer_done;        // falling edge that ends the burst

   // NOTE: every variable gets its hold value first so that no path through
   // the case statement leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      div_d     = div_q;
      sck_d     = sck_q;
      cs_n_d    = cs_n_q;
      sh_d      = sh_q;
      bits_d    = bits_q;
      rx_d      = rx_q;
      addr_d    = addr_q;
      poll_d    = poll_q;
      last_d    = last_q;
      brk_d     = brk_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      xfer_done = 1'b0;

      // Bit engine: each bit is a low half (copi stable) then a high half.
      // cipo is sampled as sck rises, the shifter advances as sck falls.
      if (bits_q != 6'd0) begin
         if (div_q == HALF_END) begin
            div_d = '0;
            sck_d = ~sck_q;
            if (!sck_q) begin
               rx_d = {rx_q[6:0], cipo};
            end else begin
               sh_d      = {sh_q[30:0], 1'b0};
               bits_d    = bits_q - 6'd1;
               xfer_done = (bits_q == 6'd1);
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = start_addr;
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               brk_d   = 1'b0;
               cs_n_d  = 1'b0;
               sh_d    = {OP_WREN, 24'h0};
               bits_d  = 6'd8;
               div_d   = '0;
               state_d = S_WREN;
            end
         end

         S_WREN: begin
            if (xfer_done) begin
               tgt_d   = S_CMD;
               state_d = S_END;
            end
         end

         // cs_n high for two half-periods, then open the next transaction.
         S_GAP: begin
            if (div_q == GAP_END) begin
               div_d   = '0;
               cs_n_d  = 1'b0;
               state_d = tgt_q;
               case (tgt_q)
                  S_CMD: begin
                     sh_d   = {OP_WRITE, addr_q, 8'h00};
                     bits_d = 6'd24;
                  end
                  S_POLL_CMD: begin
                     sh_d   = {OP_RDSR, 24'h0};
                     bits_d = 6'd8;
                     poll_d = '0;
                  end
                  default: begin
                     sh_d   = {OP_WREN, 24'h0};
                     bits_d = 6'd8;
                  end
               endcase
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         S_CMD: begin
            if (xfer_done) state_d = S_DATA;
         end

         // With the shifter empty the bus is parked (sck low, cs_n low)
         // until the next byte arrives.
         S_DATA: begin
            if (bits_q == 6'd0) begin
               if (data_valid) begin
                  sh_d   = {data_in, 24'h0};
                  bits_d = 6'd8;
                  last_d = data_last;
                  div_d  = '0;
               end
            end else if (xfer_done) begin
               addr_d = addr_q + 16'd1;
               if (last_q) begin
                  tgt_d   = S_POLL_CMD;
                  state_d = S_END;
               end else if ((addr_d & PAGE_MASK) == 16'h0000) begin
                  brk_d   = 1'b1;
                  tgt_d   = S_POLL_CMD;
                  state_d = S_END;
               end
            end
         end

         // Hold cs_n low one half-period after the last sck fall.
         S_END: begin
            if (div_q == HALF_END) begin
               div_d  = '0;
               cs_n_d = 1'b1;
               if (tgt_q == S_DONE) begin
                  err_d   = tmo_q;
                  state_d = S_DONE;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         S_POLL_CMD: begin
            if (xfer_done) begin
               sh_d    = '0;
               bits_d  = 6'd8;
               state_d = S_POLL_RD;
            end
         end

         // Status bytes follow each other in one cs_n-low window.
         S_POLL_RD: begin
            if (xfer_done) begin
               poll_d = poll_q + 1'b1;
               if (!rx_q[0]) begin
                  tgt_d   = brk_q ? S_WREN : S_DONE;
                  brk_d   = 1'b0;
                  state_d = S_END;
               end else if (poll_d == POLL_MAX) begin
                  tmo_d   = 1'b1;
                  tgt_d   = S_DONE;
                  state_d = S_END;
               end else begin
                  bits_d = 6'd8;
               end
            end
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state lives in non-blocking assignments only; blocking ones here
   // would make the result depend on process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tgt_q   <= S_IDLE;
         div_q   <= '0;
         sck_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         sh_q    <= '0;
         bits_q  <= '0;
         rx_q    <= '0;
         addr_q  <= '0;
         poll_q  <= '0;
         last_q  <= 1'b0;
         brk_q   <= 1'b0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         div_q   <= div_d;
         sck_q   <= sck_d;
         cs_n_q  <= cs_n_d;
         sh_q    <= sh_d;
         bits_q  <= bits_d;
         rx_q    <= rx_d;
         addr_q  <= addr_d;
         poll_q  <= poll_d;
         last_q  <= last_d;
         brk_q   <= brk_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode directly from registers, so reset reaches them at once.
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign error      = err_q;
   assign data_ready = (state_q == S_DATA) && (bits_q == 6'd0);
   assign cur_addr   = addr_q;
   assign sck        = sck_q;
   assign cs_n       = cs_n_q;
   assign copi       = sh_q[31];
   assign copi_oe    = (state_q == S_WREN) || (state_q == S_CMD) ||
                       (state_q == S_DATA) || (state_q == S_POLL_CMD);
   assign hold_n     = 1'b1;

endmodule
